// File: rtl/host_bus_master_pkg.sv
// Shared constants, FSM state type and burst-length helper for the host bus master.
package host_bus_master_pkg;

    localparam int unsigned AddrW      = 14;
    localparam int unsigned DataW      = 32;
    localparam int unsigned LenW       = 9;
    localparam int unsigned IrqFlagLsb = 8;
    localparam int unsigned IrqFlagMsb = 11;
    localparam int unsigned IrqFlagW   = IrqFlagMsb - IrqFlagLsb + 1;

    localparam logic [AddrW-1:0] IrqFlagAddrDefault = 14'h0004;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdAddr,
        StRdCap,
        StRsp,
        StIrqRd,
        StIrqCap,
        StIrqClr
    } state_e;

    // A zero length means one word; anything beyond max_len is clamped.
    function automatic logic [LenW-1:0] eff_len(input logic [LenW-1:0] len,
                                                input int unsigned     max_len);
        if (len == '0) return LenW'(1);
        if (32'(len) > max_len) return LenW'(max_len);
        return len;
    endfunction

endpackage

// File: rtl/host_bus_master_if.sv
// Command, response, host bus and interrupt signals of the host bus master.
interface host_bus_if;
    import host_bus_master_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [AddrW-1:0]    cmd_addr;
    logic [LenW-1:0]     cmd_len;
    logic [DataW-1:0]    cmd_wdata;
    logic                wdata_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DataW-1:0]    rsp_data;
    logic                host_cs;
    logic                host_rd;
    logic                host_wr;
    logic [AddrW-1:0]    host_addr;
    logic [DataW-1:0]    host_d4wt;
    logic [DataW-1:0]    host_d4rd;
    logic                irq;
    logic                irq_auto_clr;
    logic [IrqFlagW-1:0] irq_flags;
    logic                irq_event;
    logic                busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, rsp_ready, host_d4rd,
               irq, irq_auto_clr,
        output cmd_ready, wdata_ready, rsp_valid, rsp_data, host_cs, host_rd, host_wr,
               host_addr, host_d4wt, irq_flags, irq_event, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, rsp_ready, host_d4rd,
               irq, irq_auto_clr,
        input  cmd_ready, wdata_ready, rsp_valid, rsp_data, host_cs, host_rd, host_wr,
               host_addr, host_d4wt, irq_flags, irq_event, busy
    );

endinterface

// File: rtl/host_bus_master.sv
// Burst read/write master for the baseband host bus with automatic interrupt-flag service.
module host_bus_master
    import host_bus_master_pkg::*;
#(
    parameter logic [AddrW-1:0] IRQ_FLAG_ADDR = IrqFlagAddrDefault,
    parameter int unsigned      MAX_LEN       = 256
) (
    input logic        clk,
    input logic        rst_b,
    host_bus_if.master bus
);

    state_e              state_q, state_d;
    logic [AddrW-1:0]    addr_q, addr_d;
    logic [AddrW-1:0]    haddr_q, haddr_d;
    logic [LenW-1:0]     cnt_q, cnt_d;
    logic [DataW-1:0]    rsp_data_q, rsp_data_d;
    logic [IrqFlagW-1:0] irq_flags_q, irq_flags_d;
    logic                irq_pend;

    assign irq_pend = bus.irq_auto_clr & bus.irq;

    // addr_q is the burst pointer; haddr_q is what the bus shows and only moves on a strobe.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        haddr_d     = haddr_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        irq_flags_d = irq_flags_q;
        unique case (state_q)
            StIdle: begin
                if (irq_pend) begin
                    haddr_d = IRQ_FLAG_ADDR;
                    state_d = StIrqRd;
                end else if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_addr;
                    haddr_d = bus.cmd_addr;
                    cnt_d   = eff_len(bus.cmd_len, MAX_LEN);
                    state_d = bus.cmd_write ? StWr : StRdAddr;
                end
            end
            StWr: begin
                addr_d = addr_q + AddrW'(1);
                cnt_d  = cnt_q - LenW'(1);
                if (cnt_q == LenW'(1)) begin
                    state_d = StIdle;
                end else begin
                    haddr_d = addr_q + AddrW'(1);
                end
            end
            StRdAddr: state_d = StRdCap;
            StRdCap: begin
                rsp_data_d = bus.host_d4rd;
                state_d    = StRsp;
            end
            StRsp: begin
                if (bus.rsp_ready) begin
                    addr_d = addr_q + AddrW'(1);
                    cnt_d  = cnt_q - LenW'(1);
                    if (cnt_q == LenW'(1)) begin
                        state_d = StIdle;
                    end else begin
                        haddr_d = addr_q + AddrW'(1);
                        state_d = StRdAddr;
                    end
                end
            end
            StIrqRd: state_d = StIrqCap;
            StIrqCap: begin
                irq_flags_d = bus.host_d4rd[IrqFlagMsb:IrqFlagLsb];
                state_d     = StIrqClr;
            end
            StIrqClr: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            haddr_q     <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            irq_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            haddr_q     <= haddr_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            irq_flags_q <= irq_flags_d;
        end
    end

    // Strobes decode straight from the state register; write data passes through in WR.
    assign bus.cmd_ready   = rst_b & (state_q == StIdle) & ~irq_pend;
    assign bus.wdata_ready = (state_q == StWr);
    assign bus.host_cs     = (state_q == StWr) | (state_q == StRdAddr) |
                             (state_q == StIrqRd) | (state_q == StIrqClr);
    assign bus.host_rd     = (state_q == StRdAddr) | (state_q == StIrqRd);
    assign bus.host_wr     = (state_q == StWr) | (state_q == StIrqClr);
    assign bus.host_addr   = haddr_q;
    assign bus.host_d4wt   = (state_q == StWr)     ? bus.cmd_wdata :
                             (state_q == StIrqClr) ? (DataW'(irq_flags_q) << IrqFlagLsb) :
                                                     '0;
    assign bus.rsp_valid   = (state_q == StRsp);
    assign bus.rsp_data    = rsp_data_q;
    assign bus.irq_flags   = irq_flags_q;
    assign bus.irq_event   = (state_q == StIrqCap);
    assign bus.busy        = (state_q != StIdle);

endmodule

// File: doc/host_bus_master.md
HOST_BUS_MASTER -- requirements
Module: host_bus_master

Interface
REQ-001 Parameter IRQ_FLAG_ADDR, default 14'h0004: DWORD address of the global interrupt flag register.
REQ-002 Parameter MAX_LEN, default 256: maximum burst length in words.
REQ-003 clk  input  1  system clock, same domain as the baseband core.
REQ-004 rst_b  input  1  reset; asynchronous, active-low.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  14  start DWORD address.
REQ-009 cmd_len  input  9  burst length in words, 1..MAX_LEN; 0 is treated as 1.
REQ-010 cmd_wdata  input  32  write data; sampled once per word while the burst is active.
REQ-011 wdata_ready  output  1  pulses in the cycle that consumes cmd_wdata.
REQ-012 rsp_valid / rsp_ready / rsp_data  output / input / output  1 / 1 / 32  read response handshake.
REQ-013 host_cs, host_rd, host_wr  output  1 each  bus strobes.
REQ-014 host_addr  output  14  bus address.
REQ-015 host_d4wt  output  32  bus write data.
REQ-016 host_d4rd  input  32  bus read data.
REQ-017 irq  input  1  level interrupt from the core.
REQ-018 irq_auto_clr  input  1  enables automatic interrupt service.
REQ-019 irq_flags  output  4  last serviced flag bits [11:8].
REQ-020 irq_event  output  1  one-cycle pulse when irq_flags is updated.
REQ-021 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-022 States: IDLE, WR, RD_ADDR, RD_CAP, RSP, IRQ_RD, IRQ_CAP, IRQ_CLR.
REQ-023 cmd_ready SHALL be 1 only in IDLE when no irq service is pending.
- On acceptance: latch cmd_write, cmd_addr, cmd_len (0 → 1).
- Next state: WR for writes, RD_ADDR for reads.
REQ-024 WR, one cycle per word:
- host_cs=1, host_wr=1, host_addr=current address, host_d4wt=cmd_wdata, wdata_ready=1.
- Address +1 per word; 14-bit wrap-around from 14'h3FFF to 0.
- Return to IDLE after the last word.
REQ-025 RD_ADDR: host_cs=1, host_rd=1 for one cycle.
REQ-026 RD_CAP:
- host_cs=0, host_rd=0, host_addr held unchanged.
- host_d4rd is registered into rsp_data at the end of this cycle (read latency 1).
REQ-027 RSP:
- rsp_valid=1, rsp_data stable until rsp_ready.
- On handshake: address +1, remaining count -1.
- Next state: RD_ADDR if words remain, otherwise IDLE.
- Only one read is ever outstanding.
REQ-028 rsp_ready held low SHALL stall the FSM in RSP indefinitely with no bus activity.
REQ-029 Outside WR/RD_ADDR/IRQ_RD/IRQ_CLR: host_cs=host_rd=host_wr=0, host_d4wt=0.
- host_addr holds its last value, including in IDLE.
REQ-030 An irq service is pending when irq_auto_clr=1 and irq=1.
- It is taken only from IDLE, with priority over a simultaneous cmd_valid.
- A burst in progress is never interrupted.
REQ-031 IRQ_RD: read cycle at IRQ_FLAG_ADDR.
REQ-032 IRQ_CAP: address held; irq_flags <= host_d4rd[11:8]; irq_event=1.
REQ-033 IRQ_CLR: write cycle at IRQ_FLAG_ADDR with host_d4wt = {20'h0, irq_flags, 8'h0}, then IDLE.
REQ-034 Flags read as 0 SHALL still perform the write, then return to IDLE.
- If irq is still high, service repeats.
REQ-035 With irq_auto_clr=0: irq is ignored; irq_flags and irq_event are unchanged and held at their last value / 0 respectively.

Reset
REQ-036 Asynchronous assertion SHALL force IDLE, including mid-burst.
- Burst state is discarded; no response is produced for the aborted command.
- All outputs go to 0, except cmd_ready, which reflects IDLE once rst_b deasserts.

Structure
REQ-037 A shared package holds:
- FSM state enumeration.
- IRQ_FLAG_ADDR default.
- Bus address width (14) and data width (32).
- Interrupt flag field position (11:8).
REQ-038 Single module, no sub-modules.

Verification
REQ-039 Write burst: cmd addr=14'h0100, len=3, wdata A,B,C.
- Three consecutive host_wr cycles at 0x100..0x102 with matching host_d4wt.
- Then IDLE.
REQ-040 Read burst: addr=14'h2000, len=2, model returns 0x11/0x22 one cycle after the strobe.
- rsp_data 0x11, then 0x22.
- host_addr held during each RD_CAP.
REQ-041 Backpressure: rsp_ready=0 for 10 cycles on the first read.
- No further strobes while stalled.
- Correct data when rsp_ready rises.
REQ-042 IRQ: irq_auto_clr=1, irq high, flag register = 0x0000_0500.
- Read then write of 0x500 at IRQ_FLAG_ADDR.
- irq_flags=4'b0101, one irq_event pulse.
REQ-043 Collision and wrap:
- irq and cmd_valid rise together: irq service first, then the command.
- Write burst at 14'h3FFF, len=2: second write at 14'h0000.
REQ-044 Reset mid-read burst (len=5, after 2 words): all strobes 0 immediately; cmd_ready=1 after release.
